// File: rtl/de1soc_io_pkg.sv
// ============================================================================
//  Package : de1soc_io_pkg
//  Brief   : Shared board constants for the DE1-SoC switch input stage.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package de1soc_io_pkg;

    localparam int NUM_SW        = 10;
    localparam int SYS_CLK_HZ    = 50_000_000;
    localparam int DEBOUNCE_MS   = 10;
    localparam int STABLE_CYCLES = (SYS_CLK_HZ / 1000) * DEBOUNCE_MS;

    // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sw_debounce_cell.sv
// ============================================================================
//  Module : sw_debounce_cell
//  Brief  : One switch bit: synchroniser chain, qualification counter,
//           debounced level register and one-cycle change pulse.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module sw_debounce_cell #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = de1soc_io_pkg::STABLE_CYCLES
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_changed,
    output logic accept
);

    import de1soc_io_pkg::*;

    localparam int                 c_cnt_w   = cnt_width(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_stable;
    logic                   r_changed;
    logic                   w_sync;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    // Asserted during the cycle before the stable register takes the new level.
    assign accept     = (w_sync != r_stable) && (r_cnt == c_cnt_max);
    assign sw_stable  = r_stable;
    assign sw_changed = r_changed;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sw_raw};
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cnt     <= '0;
            r_stable  <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_stable  <= w_sync;
                r_changed <= 1'b1;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sw_debounce_sync.sv
// ============================================================================
//  Module : sw_debounce_sync
//  Brief  : Per-bit synchronise/debounce of the slide switches feeding the
//           switch PIO, with change pulses and a saturating event counter.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module sw_debounce_sync #(
    parameter int WIDTH         = de1soc_io_pkg::NUM_SW,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = de1soc_io_pkg::STABLE_CYCLES,
    parameter int CNT_W         = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_changed,
    output logic             sw_event,
    input  logic             event_clr,
    output logic [CNT_W-1:0] event_count
);

    import de1soc_io_pkg::*;

    logic [WIDTH-1:0] w_accept;
    logic             r_event;
    logic [CNT_W-1:0] r_count;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        sw_debounce_cell #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_cell (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .sw_raw        (sw_raw[gi]),
            .sw_stable     (sw_stable[gi]),
            .sw_changed    (sw_changed[gi]),
            .accept        (w_accept[gi])
        );
    end

    assign sw_event    = r_event;
    assign event_count = r_count;

    // Registered from the cells' pre-acceptance terms so it lines up with sw_changed.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_event <= 1'b0;
        end else begin
            r_event <= |w_accept;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_count <= '0;
        end else if (event_clr) begin
            r_count <= '0;
        end else if (r_event && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sw_debounce_sync.sv
// ============================================================================
//  Module : tb_sw_debounce_sync
//  Brief  : Directed bench for sw_debounce_sync with a pulse scoreboard.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sw_debounce_sync;

    localparam int WIDTH = 10;
    localparam int CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] chg;
        logic [WIDTH-1:0] stb;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] sw_raw = '0;
    logic             event_clr = 1'b0;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_changed;
    logic             sw_event;
    logic [CNT_W-1:0] event_count;

    exp_t             q[$];
    logic [WIDTH-1:0] exp_stable = '0;
    int               n_vec = 0;
    int               n_err = 0;
    int               n_p3  = 0;

    sw_debounce_sync #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sw_raw        (sw_raw),
        .sw_stable     (sw_stable),
        .sw_changed    (sw_changed),
        .sw_event      (sw_event),
        .event_clr     (event_clr),
        .event_count   (event_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] chg);
        exp_stable = exp_stable ^ chg;
        q.push_back('{chg: chg, stb: exp_stable});
    endtask

    // Every change pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (sw_changed !== '0) begin
            exp_t e;
            n_p3 += int'(sw_changed[3]);
            chk("event_or", 32'(sw_event), 32'd1);
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'(sw_changed), 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_changed", 32'(sw_changed), 32'(e.chg));
                chk("sb_stable",  32'(sw_stable),  32'(e.stb));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        #2;
        chk("rst_stable",  32'(sw_stable),   32'd0);
        chk("rst_changed", 32'(sw_changed),  32'd0);
        chk("rst_count",   32'(event_count), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Clean edge on bit 0
        sw_raw[0] = 1'b1;
        push_exp(10'h001);
        tick(9);
        chk("clean_early", 32'(sw_stable), 32'h000);
        tick(1);
        chk("clean_stable",  32'(sw_stable),  32'h001);
        chk("clean_changed", 32'(sw_changed), 32'h001);
        chk("clean_event",   32'(sw_event),   32'd1);
        tick(1);
        chk("clean_pulse_end", 32'(sw_changed),  32'h000);
        chk("clean_count",     32'(event_count), 32'd1);

        // Bounce on bit 3, ending high
        for (int i = 0; i < 10; i++) begin
            sw_raw[3] = ~sw_raw[3];
            tick(3);
        end
        chk("bounce_none", 32'(n_p3), 32'd0);
        sw_raw[3] = 1'b1;
        push_exp(10'h008);
        tick(9);
        chk("bounce_early", 32'(sw_stable[3]), 32'd0);
        tick(1);
        chk("bounce_stable", 32'(sw_stable[3]), 32'd1);
        tick(3);
        chk("bounce_pulses", 32'(n_p3),        32'd1);
        chk("bounce_count",  32'(event_count), 32'd2);

        // Glitch on bit 5: 7 cycles rejected, 8 cycles accepted
        sw_raw[5] = 1'b1;
        tick(7);
        sw_raw[5] = 1'b0;
        tick(15);
        chk("glitch7_stable", 32'(sw_stable[5]), 32'd0);
        chk("glitch7_count",  32'(event_count),  32'd2);
        sw_raw[5] = 1'b1;
        tick(8);
        sw_raw[5] = 1'b0;
        push_exp(10'h020);
        push_exp(10'h020);
        tick(2);
        chk("glitch8_rise", 32'(sw_stable[5]), 32'd1);
        tick(8);
        chk("glitch8_fall", 32'(sw_stable[5]), 32'd0);
        tick(1);
        chk("glitch8_count", 32'(event_count), 32'd4);

        // Simultaneous bits 1 and 9
        sw_raw[1] = 1'b1;
        sw_raw[9] = 1'b1;
        push_exp(10'h202);
        tick(10);
        chk("simul_changed", 32'(sw_changed), 32'h202);
        chk("simul_event",   32'(sw_event),   32'd1);
        tick(1);
        chk("simul_event_end", 32'(sw_event),    32'd0);
        chk("simul_count",     32'(event_count), 32'd5);

        // Twenty events on bit 7: saturate without wrapping
        for (int i = 1; i <= 20; i++) begin
            sw_raw[7] = ~sw_raw[7];
            push_exp(10'h080);
            tick(11);
            if (i == 9)  chk("sat_below", 32'(event_count), 32'd14);
            if (i == 10) chk("sat_reach", 32'(event_count), 32'd15);
        end
        chk("sat_hold", 32'(event_count), 32'hF);

        // Clear on the cycle of sw_event wins and drops the event
        sw_raw[7] = 1'b1;
        push_exp(10'h080);
        tick(10);
        chk("clr_event", 32'(sw_event), 32'd1);
        event_clr = 1'b1;
        tick(1);
        event_clr = 1'b0;
        chk("clr_count", 32'(event_count), 32'd0);
        tick(2);
        chk("clr_dropped", 32'(event_count), 32'd0);

        // Reset mid-qualification with all switches high
        sw_raw = 10'h3FF;
        tick(5);
        chk("pre_rst_stable", 32'(sw_stable), 32'h28B);
        chk("pre_rst_queue",  32'(q.size()),  32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_stable",  32'(sw_stable),   32'd0);
        chk("arst_changed", 32'(sw_changed),  32'd0);
        chk("arst_event",   32'(sw_event),    32'd0);
        chk("arst_count",   32'(event_count), 32'd0);
        exp_stable = '0;
        tick(2);
        rst_n = 1'b1;
        push_exp(10'h3FF);
        tick(9);
        chk("requal_early", 32'(sw_stable), 32'h000);
        tick(1);
        chk("requal_stable",  32'(sw_stable),  32'h3FF);
        chk("requal_changed", 32'(sw_changed), 32'h3FF);
        tick(1);
        chk("requal_count", 32'(event_count), 32'd1);
        tick(3);
        chk("final_queue", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
